// File: rtl/switch_box_config_loader.sv
// Streams a configuration image in CW-bit words into a shadow register and
// commits it atomically onto the switch box configuration bus c.
module switch_box_config_loader #(
    parameter  int WS    = 7,
    parameter  int WD    = 6,
    parameter  int CW    = 8,
    localparam int CFG_W = WS * 6 + (WD / 2) * 6,
    localparam int NW    = (CFG_W + CW - 1) / CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             clear,
    input  logic [CW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CFG_W-1:0] c,
    output logic             cfg_valid,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] c_q, c_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic [CFG_W-1:0] word_mask;
    int unsigned      word_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            c_q         <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            c_q         <= c_d;
            cfg_valid_q <= cfg_valid_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        c_d         = c_q;
        cfg_valid_d = cfg_valid_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        word_off    = 32'(idx_q) * CW;
        // Shifting into a CFG_W-wide vector drops last-word bits beyond the image.
        word_mask   = CFG_W'({CW{1'b1}}) << word_off;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    c_d         = '0;
                    cfg_valid_d = 1'b0;
                end else if (start) begin
                    shadow_d = '0;
                    idx_d    = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (in_valid) begin
                    shadow_d = (shadow_q & ~word_mask) | (CFG_W'(in_data) << word_off);
                    if (idx_q == IW'(NW - 1)) begin
                        state_d = S_COMMIT;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_COMMIT: begin
                c_d         = shadow_q;
                cfg_valid_d = 1'b1;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign c         = c_q;
    assign cfg_valid = cfg_valid_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
